// File: rtl/mul_pkg.sv
// Shared definitions for the mul_seq sequential multiplier: FSM state
// encoding and the iteration-counter width helper.
package mul_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for n iterations: clog2(n), never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/result bundle for mul_seq: operands and start in, product,
// busy and fin out.
interface mul_seq_if #(
  parameter int W = 8
);
  logic           start;
  logic           sgn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] o;
  logic           busy;
  logic           fin;

  modport master (output start, sgn, a, b, input o, busy, fin);
  modport slave  (input start, sgn, a, b, output o, busy, fin);
endinterface

// File: rtl/mul_step.sv
// One radix-2^R shift-add step: acc_out = acc_in + mcand * bits.
// mcand is already shifted into position by the caller.
module mul_step #(
  parameter int W = 8,
  parameter int R = 1
) (
  input  logic [2*W-1:0] acc_in,
  input  logic [2*W-1:0] mcand,
  input  logic [R-1:0]   bits,
  output logic [2*W-1:0] acc_out
);

  logic [2*W-1:0] pp_s;

  // Sum the shifted copies of mcand selected by each multiplier bit.
  always_comb begin
    pp_s = {(2*W){1'b0}};
    for (int i = 0; i < R; i++) begin
      pp_s = pp_s + ((mcand << i) & {(2*W){bits[i]}});
    end
    acc_out = acc_in + pp_s;
  end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: W x W sequential multiplier retiring R multiplier bits per
// cycle, so a product takes N = W/R cycles from start to fin.
// Optional feature: define MUL_SIGNED_EN to honour sgn (two's-complement
// operands via magnitude multiply plus final negate). Without it every
// operation is unsigned and sgn is ignored.
module mul_seq
  import mul_pkg::*;
#(
  parameter int W = 8,
  parameter int R = 1
) (
  input  logic     ck,
  input  logic     rst,
  mul_seq_if.slave bus
);

  localparam int N  = W / R;
  localparam int CW = cnt_width(N);

  if ((W < 2) || (R < 1) || ((W % R) != 0)) begin : g_param_check
    $error("mul_seq: W must be >= 2 and divisible by R");
  end

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [2*W-1:0]  acc_r;
  logic [2*W-1:0]  mcand_r;
  logic [W-1:0]    mplier_r;
  logic [2*W-1:0]  o_r;
  logic            busy_r;
  logic            fin_r;
  logic [W-1:0]    a_abs_s;
  logic [W-1:0]    b_abs_s;
  logic [2*W-1:0]  acc_step_s;
  logic [2*W-1:0]  res_s;
  logic            load_s;
  logic            done_s;
  logic            last_s;

  assign last_s = (cnt_r == CW'(N - 1));

`ifdef MUL_SIGNED_EN
  logic neg_s;
  logic neg_r;

  // Operand magnitudes and result sign; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    a_abs_s = (bus.sgn & bus.a[W-1]) ? (~bus.a + W'(1'b1)) : bus.a;
    b_abs_s = (bus.sgn & bus.b[W-1]) ? (~bus.b + W'(1'b1)) : bus.b;
    neg_s   = bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
  end

  // Sign flag captured with the operands.
  always_ff @(posedge ck) begin
    if (rst) begin
      neg_r <= 1'b0;
    end else if (load_s) begin
      neg_r <= neg_s;
    end else begin
      neg_r <= neg_r;
    end
  end

  // Final product, negated in 2W bits when the operand signs differed.
  always_comb begin
    res_s = neg_r ? (~acc_step_s + (2*W)'(1'b1)) : acc_step_s;
  end
`else
  logic sgn_unused_s;
  assign sgn_unused_s = bus.sgn;

  // Unsigned build: operands pass straight through.
  always_comb begin
    a_abs_s = bus.a;
    b_abs_s = bus.b;
  end

  // Unsigned build: the accumulator is the product.
  always_comb begin
    res_s = acc_step_s;
  end
`endif

  mul_step #(.W(W), .R(R)) u_step (
    .acc_in  (acc_r),
    .mcand   (mcand_r),
    .bits    (mplier_r[R-1:0]),
    .acc_out (acc_step_s)
  );

  // State register.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: accept start only in IDLE, leave RUN on the last iteration.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = IDLE;
          done_s       = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath: load operands on start, then one shift-add per RUN cycle.
  always_ff @(posedge ck) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      mcand_r  <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
    end else if (load_s) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      mcand_r  <= {{W{1'b0}}, a_abs_s};
      mplier_r <= b_abs_s;
    end else if (state_r == RUN) begin
      cnt_r    <= cnt_r + CW'(1'b1);
      acc_r    <= acc_step_s;
      mcand_r  <= mcand_r << R;
      mplier_r <= mplier_r >> R;
    end else begin
      cnt_r    <= cnt_r;
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
    end
  end

  // Registered outputs: product updates only with the fin pulse.
  always_ff @(posedge ck) begin
    if (rst) begin
      o_r    <= {(2*W){1'b0}};
      busy_r <= 1'b0;
      fin_r  <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN);
      fin_r  <= done_s;
      o_r    <= done_s ? res_s : o_r;
    end
  end

  assign bus.o    = o_r;
  assign bus.busy = busy_r;
  assign bus.fin  = fin_r;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: W=8/R=1, W=8/R=2 and W=16/R=2 instances.
// Expected products follow the MUL_SIGNED_EN setting of the build.
module tb_mul_seq;

`ifdef MUL_SIGNED_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic ck = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 ck = ~ck;

  mul_seq_if #(.W(8))  b8 ();
  mul_seq_if #(.W(8))  b8r2 ();
  mul_seq_if #(.W(16)) b16 ();

  mul_seq #(.W(8),  .R(1)) dut8   (.ck(ck), .rst(rst), .bus(b8.slave));
  mul_seq #(.W(8),  .R(2)) dut8r2 (.ck(ck), .rst(rst), .bus(b8r2.slave));
  mul_seq #(.W(16), .R(2)) dut16  (.ck(ck), .rst(rst), .bus(b16.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
    b8.a = a; b8.b = b; b8.sgn = s; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
  endtask

  // Wait for fin, checking busy stays high until then, latency and product.
  task automatic wait8(input string tag, input int lat, input logic [15:0] exp);
    int n = 0;
    int low = 0;
    while (b8.fin !== 1'b1 && n < 40) begin
      if (b8.busy !== 1'b1) low++;
      tick();
      n++;
    end
    check({tag, " lat"}, 64'(n), 64'(lat));
    check({tag, " o"}, 64'(b8.o), 64'(exp));
    check({tag, " busy@fin"}, 64'(b8.busy), 64'd0);
    check({tag, " busy low"}, 64'(low), 64'd0);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp);
    int n = 0;
    b16.a = a; b16.b = b; b16.sgn = s; b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    while (b16.fin !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " lat"}, 64'(n), 64'd8);
    check({tag, " o"}, 64'(b16.o), 64'(exp));
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [31:0] ea;
    logic [31:0] eb;
    if (SE && s) begin
      ea = {{16{a[15]}}, a};
      eb = {{16{b[15]}}, b};
    end else begin
      ea = {16'd0, a};
      eb = {16'd0, b};
    end
    return ea * eb;
  endfunction

  initial begin
    int nfin;
    int fin_at;
    logic [15:0] o_at;
    logic [15:0] ra;
    logic [15:0] rb;
    logic rs;

    rst = 1'b1;
    b8.start = 1'b0;   b8.sgn = 1'b0;   b8.a = 8'd0;    b8.b = 8'd0;
    b8r2.start = 1'b0; b8r2.sgn = 1'b0; b8r2.a = 8'd0;  b8r2.b = 8'd0;
    b16.start = 1'b0;  b16.sgn = 1'b0;  b16.a = 16'd0;  b16.b = 16'd0;
    repeat (3) tick();
    check("rst o", 64'(b8.o), 64'd0);
    check("rst fin", 64'(b8.fin), 64'd0);
    check("rst busy", 64'(b8.busy), 64'd0);
    check("rst o16", 64'(b16.o), 64'd0);
    rst = 1'b0;
    tick();

    // Unsigned full-scale product.
    start8(8'hFF, 8'hFF, 1'b0);
    wait8("ff*ff", 8, 16'hFE01);

    // Signed corner cases; unsigned build treats operands as plain bits.
    start8(8'h80, 8'h80, 1'b1);
    wait8("s80*80", 8, 16'h4000);
    start8(8'hFF, 8'h01, 1'b1);
    wait8("sff*01", 8, SE ? 16'hFFFF : 16'h00FF);
    start8(8'hFD, 8'h05, 1'b1);
    wait8("sfd*05", 8, SE ? 16'hFFF1 : 16'h04F1);
    start8(8'hFD, 8'h05, 1'b0);
    wait8("ufd*05", 8, 16'h04F1);

    // Busy protection: second start at t0+3 must be ignored.
    start8(8'd3, 8'd5, 1'b0);
    nfin = 0; fin_at = 0; o_at = 16'd0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        b8.a = 8'd7; b8.b = 8'd7; b8.start = 1'b1;
      end
      tick();
      b8.start = 1'b0;
      if (b8.fin === 1'b1) begin
        nfin++; fin_at = k; o_at = b8.o;
      end
    end
    check("busy fins", 64'(nfin), 64'd1);
    check("busy fin_at", 64'(fin_at), 64'd8);
    check("busy o", 64'(o_at), 64'h000F);

    // Back-to-back: next start issued during the fin cycle.
    start8(8'd2, 8'd2, 1'b0);
    wait8("b2b first", 8, 16'h0004);
    start8(8'h10, 8'h10, 1'b0);
    wait8("b2b second", 8, 16'h0100);

    // Reset in the middle of an operation aborts it.
    start8(8'd5, 8'd5, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst o", 64'(b8.o), 64'd0);
    check("midrst fin", 64'(b8.fin), 64'd0);
    check("midrst busy", 64'(b8.busy), 64'd0);
    nfin = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (b8.fin === 1'b1) nfin++;
    end
    check("midrst no fin", 64'(nfin), 64'd0);
    start8(8'd2, 8'd3, 1'b0);
    wait8("after rst", 8, 16'h0006);

    // Reset wins over a simultaneous start.
    rst = 1'b1; b8.a = 8'd9; b8.b = 8'd9; b8.start = 1'b1;
    tick();
    rst = 1'b0; b8.start = 1'b0;
    check("rst>start busy", 64'(b8.busy), 64'd0);
    tick();
    check("rst>start idle", 64'(b8.busy), 64'd0);

    // Radix-4 on W=8: four cycles.
    begin
      int n = 0;
      b8r2.a = 8'hFF; b8r2.b = 8'hFF; b8r2.sgn = 1'b0; b8r2.start = 1'b1;
      tick();
      b8r2.start = 1'b0;
      while (b8r2.fin !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check("r2 lat", 64'(n), 64'd4);
      check("r2 o", 64'(b8r2.o), 64'hFE01);
    end

    // W=16, R=2.
    run16("w16 ffff*2", 16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      run16("w16 rand", ra, rb, rs, ref16(ra, rb, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
